// File: rtl/dca_lpi_burden_responder_if.sv
// ---------------------------------------------------------------------------
// dca_lpi_burden_responder_if
//   LPI request/response link between an initiator and a responder.
//   x channel (initiator -> responder): xvalid/xready handshake carrying
//     xwrite, xaddr, xwdata and the burden tag xburden.
//   y channel (responder -> initiator): yvalid/yready handshake carrying
//     ydata = {burden, rdata}.
//   Modports: master = initiator side, slave = responder side.
// ---------------------------------------------------------------------------
interface dca_lpi_burden_responder_if #(
    parameter int BW_ADDR   = 32,
    parameter int BW_DATA   = 32,
    parameter int BW_BURDEN = 1
);
    logic                          xvalid;
    logic                          xready;
    logic                          xwrite;
    logic [BW_ADDR-1:0]            xaddr;
    logic [BW_DATA-1:0]            xwdata;
    logic [BW_BURDEN-1:0]          xburden;
    logic                          yvalid;
    logic                          yready;
    logic [BW_BURDEN+BW_DATA-1:0]  ydata;

    modport master (
        output xvalid, xwrite, xaddr, xwdata, xburden, yready,
        input  xready, yvalid, ydata
    );

    modport slave (
        input  xvalid, xwrite, xaddr, xwdata, xburden, yready,
        output xready, yvalid, ydata
    );
endinterface

// File: rtl/dca_lpi_burden_responder.sv
// ---------------------------------------------------------------------------
// dca_lpi_burden_responder
//   Responder endpoint of the LPI link. Requests accepted on the x channel
//   drive a fixed-latency memory backend; read data returns on the y channel
//   with the request's burden tag in the MSBs. Outstanding reads are limited
//   to DEPTH so the response FIFOs can never overflow.
//
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     clear           synchronous flush of all state (wins over everything)
//     sx              LPI slave interface (x request / y response channels)
//     mem_req         backend access strobe (= request accept)
//     mem_write       backend write enable
//     mem_addr        backend address
//     mem_wdata       backend write data
//     mem_rdata       backend read data, valid READ_LATENCY cycles after req
//     busy            at least one response outstanding
//
//   Optional feature macro: DCA_LPI_RESPONDER_WRITE_ACK_EN
//     When defined, writes also take a credit and return one y response
//     carrying {burden, 0}, so every request gets exactly one response.
// ---------------------------------------------------------------------------
module dca_lpi_burden_responder #(
    parameter int BW_ADDR      = 32,
    parameter int BW_DATA      = 32,
    parameter int BW_BURDEN    = 1,
    parameter int DEPTH        = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    dca_lpi_burden_responder_if.slave sx,
    output logic                      mem_req,
    output logic                      mem_write,
    output logic [BW_ADDR-1:0]        mem_addr,
    output logic [BW_DATA-1:0]        mem_wdata,
    input  logic [BW_DATA-1:0]        mem_rdata,
    output logic                      busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Full when the wrap bits differ and the index bits match.
    function automatic logic ptr_full(input logic [PW-1:0] wr, input logic [PW-1:0] rd);
        return (wr[PW-1] != rd[PW-1]) && (wr[AW-1:0] == rd[AW-1:0]);
    endfunction

    logic [PW-1:0]           r_outstanding;
    logic [PW-1:0]           r_bwr_ptr;
    logic [PW-1:0]           r_dwr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [READ_LATENCY-1:0] r_pipe_vld;
    logic [BW_BURDEN-1:0]    r_bfifo [DEPTH];
    logic [BW_DATA-1:0]      r_dfifo [DEPTH];

    logic                    w_xready;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_mature;
    logic [BW_DATA-1:0]      w_mature_data;
    logic                    w_d_empty;
    logic                    w_pop;

    // Request acceptance and backend drive
    assign w_xready  = ~clear & (r_outstanding < PW'(DEPTH));
    assign w_accept  = sx.xvalid & w_xready;
    assign sx.xready = w_xready;

    assign mem_req   = w_accept;
    assign mem_write = sx.xwrite;
    assign mem_addr  = sx.xaddr;
    assign mem_wdata = sx.xwdata;

`ifdef DCA_LPI_RESPONDER_WRITE_ACK_EN
    // Every accepted request takes a credit; write entries ride the pipe
    // with a flag so their slot is filled with zero data at maturity.
    logic [READ_LATENCY-1:0] r_pipe_wr;

    assign w_push        = w_accept;
    assign w_mature_data = r_pipe_wr[READ_LATENCY-1] ? '0 : mem_rdata;

    always_ff @(posedge clk) begin
        r_pipe_wr[0] <= sx.xwrite;
        for (int i = 1; i < READ_LATENCY; i++) begin
            r_pipe_wr[i] <= r_pipe_wr[i-1];
        end
    end
`else
    assign w_push        = w_accept & ~sx.xwrite;
    assign w_mature_data = mem_rdata;
`endif

    assign w_mature = r_pipe_vld[READ_LATENCY-1];

    // Response side: both FIFOs pop together, so they share one read pointer
    assign w_d_empty = (r_dwr_ptr == r_rd_ptr);
    assign w_pop     = ~w_d_empty & sx.yready;
    assign sx.yvalid = ~w_d_empty;
    assign sx.ydata  = w_d_empty ? '0 : {r_bfifo[r_rd_ptr[AW-1:0]], r_dfifo[r_rd_ptr[AW-1:0]]};
    assign busy      = (r_outstanding != '0);

    // Control state: credits, pointers, latency pipe valid bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
            r_bwr_ptr     <= '0;
            r_dwr_ptr     <= '0;
            r_rd_ptr      <= '0;
            r_pipe_vld    <= '0;
        end else if (clear) begin
            r_outstanding <= '0;
            r_bwr_ptr     <= '0;
            r_dwr_ptr     <= '0;
            r_rd_ptr      <= '0;
            r_pipe_vld    <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_outstanding <= r_outstanding + PW'(1);
                2'b01:   r_outstanding <= r_outstanding - PW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            if (w_push)   r_bwr_ptr <= r_bwr_ptr + PW'(1);
            if (w_mature) r_dwr_ptr <= r_dwr_ptr + PW'(1);
            if (w_pop)    r_rd_ptr  <= r_rd_ptr + PW'(1);
            r_pipe_vld[0] <= w_push;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
            end
        end
    end

    // FIFO storage: contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (w_push)   r_bfifo[r_bwr_ptr[AW-1:0]] <= sx.xburden;
        if (w_mature) r_dfifo[r_dwr_ptr[AW-1:0]] <= w_mature_data;
    end

`ifndef SYNTHESIS
    logic [PW-1:0] w_b_cnt;
    logic [PW-1:0] w_d_cnt;
    assign w_b_cnt = r_bwr_ptr - r_rd_ptr;
    assign w_d_cnt = r_dwr_ptr - r_rd_ptr;

    a_burden_ge_data: assert property (@(posedge clk) disable iff (rst) w_b_cnt >= w_d_cnt);
    a_credit_match:   assert property (@(posedge clk) disable iff (rst) r_outstanding == w_b_cnt);
    a_bfifo_no_ovf:   assert property (@(posedge clk) disable iff (rst)
                                       !(w_push && ptr_full(r_bwr_ptr, r_rd_ptr)));
    a_dfifo_no_ovf:   assert property (@(posedge clk) disable iff (rst)
                                       !(w_mature && ptr_full(r_dwr_ptr, r_rd_ptr)));
`endif

endmodule

// File: doc/dca_lpi_burden_responder.md
Name: dca_lpi_burden_responder

Overview:
- Responder-side endpoint of the LPI request/response link with burden tagging.
- Accepts requests on the x channel and drives a fixed-latency memory backend.
- Returns read data on the y channel with the request's burden field carried in the MSBs of ydata.
- Credit-limits outstanding reads so the initiator-side tracker never sees more responses than it issued.

Parameters:
BW_ADDR, 32, request address width
BW_DATA, 32, data width
BW_BURDEN, 1, burden tag width echoed in ydata MSBs
DEPTH, 4, max outstanding reads; power of 2, >=2
READ_LATENCY, 1, backend cycles from mem_req to valid mem_rdata; >=1

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
clear  input  1  synchronous flush of all state
sx_xvalid  input  1  request valid
sx_xready  output  1  request ready
sx_xwrite  input  1  1 = write, 0 = read
sx_xaddr  input  BW_ADDR  request address
sx_xwdata  input  BW_DATA  write data
sx_xburden  input  BW_BURDEN  tag to echo with the response
sx_yvalid  output  1  response valid
sx_yready  input  1  response ready
sx_ydata  output  BW_BURDEN+BW_DATA  {burden, rdata}
mem_req  output  1  backend access strobe
mem_write  output  1  backend write enable
mem_addr  output  BW_ADDR  backend address
mem_wdata  output  BW_DATA  backend write data
mem_rdata  input  BW_DATA  backend read data, valid READ_LATENCY cycles after a read mem_req
busy  output  1  outstanding count != 0

Behaviour:
- Reset (rst=1, async):
  - outstanding = 0; both FIFOs empty; latency pipe valid bits = 0.
  - sx_yvalid = 0, sx_ydata = 0, busy = 0.
  - sx_xready = 1 once rst deasserts.
- clear (sync, priority over all other updates in the same cycle): same state as reset. Reads still in the backend pipe are dropped, because their pipe valid bits are zeroed. sx_xready = 0 during the clear cycle.
- sx_xready = ~clear & (outstanding < DEPTH). It does not depend on sx_xvalid or sx_xwrite.
- Accept = sx_xvalid & sx_xready.
- Backend drive:
  - mem_req = accept (combinational).
  - mem_write = sx_xwrite; mem_addr and mem_wdata pass through.
- Write accept: no response, no credit used.
- Read accept:
  - sx_xburden is pushed into the burden FIFO (DEPTH entries).
  - A 1 enters the READ_LATENCY-deep valid shift pipe.
  - outstanding increments.
- Pipe-valid bit at depth READ_LATENCY asserted: mem_rdata is captured into the data FIFO (DEPTH entries) at that edge.
  - A read accepted in cycle T gives sx_yvalid=1 no earlier than cycle T+READ_LATENCY+1.
- Output:
  - sx_yvalid = data FIFO non-empty.
  - sx_ydata = {burden FIFO head, data FIFO head}; held stable while sx_yvalid & ~sx_yready.
  - y handshake: pop both FIFOs and decrement outstanding.
- Simultaneous read accept and y handshake: outstanding unchanged; both FIFO push and pop occur.
- Invariant: entries in flight plus entries in the data FIFO never exceed DEPTH, so the FIFOs cannot overflow. Also burden FIFO count >= data FIFO count. An overflow or underflow is a design bug and is flagged by an assertion in simulation.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. Full means MSBs differ with the remaining bits equal.
- Responses are returned strictly in request order.

Optional Feature:
DCA_LPI_RESPONDER_WRITE_ACK_EN
- Defined:
  - A write accept also consumes a credit.
  - It pushes its burden and enters the latency pipe as a "write" entry. At maturity it pushes zero data instead of mem_rdata.
  - Every request yields exactly one y response, in order.
- Undefined: writes produce no response and consume no credit, as described above.

Test Plan:
- Single read, READ_LATENCY=1, burden=1, mem_rdata=0xA5A5_0001, sx_yready=1: accept in cycle 0 -> sx_yvalid in cycle 2, sx_ydata=0x1_A5A5_0001; busy returns to 0 after the handshake.
- DEPTH=4, sx_yready=0, 6 back-to-back reads: 4 are accepted, then sx_xready=0. Raise sx_yready: responses come out with burdens in issue order 1,0,1,1, and sx_xready returns 1 on the cycle after the first pop.
- Streaming reads with sx_yready=1 and READ_LATENCY=3: one response per cycle after a 4-cycle fill; outstanding stays constant on simultaneous accept and pop.
- Interleaved write/read/write/read: only 2 y responses; mem_write pulses on cycles 0 and 2; outstanding peaks at 2.
- clear asserted one cycle after 2 reads are accepted (still in flight): sx_yvalid stays 0 afterwards, late mem_rdata is ignored, outstanding=0, and sx_xready=1 on the next cycle.
- rst pulsed asynchronously mid-stream while sx_yvalid=1: sx_yvalid drops immediately and all state is cleared. With DCA_LPI_RESPONDER_WRITE_ACK_EN defined, a single write yields sx_ydata={burden, 0}.
